base_rrmux: RTL and testbench
=============================

Name: base_rrmux

Overview:
- N-way round-robin arbiter that shares one valid/ready output channel among `ways` requesting valid/ready input channels.
- The winning beat is captured into a one-entry output register, so the output is fully registered.
- Sits between multiple producers and a single consumer; composes directly with the other base_* valid/ready cells.

Parameters:
- width, 1: data bits per beat.
- ways, 2: number of input channels, ≥2, need not be a power of two.
- selw, $clog2(ways): width of the source-index field (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- i_v  input  ways  per-input valid; bit k belongs to input k.
- i_d  input  ways*width  per-input data; input k occupies slice [k*width +: width].
- i_r  output  ways  per-input ready; at most one bit set.
- o_v  output  1  output valid (registered).
- o_d  output  width  output data (registered).
- o_s  output  selw  index of the input that supplied the current o_d (registered).
- o_r  input  1  output ready.
- i_e  input  ways  end-of-packet flag per input; present only with BASE_RRMUX_LOCK_EN.

Behaviour:
- Reset (reset=0, asynchronous): o_v=0, o_d=0, o_s=0, priority pointer ptr=0. i_r=0 while reset is asserted.
- Handshakes:
  - A transfer occurs on any channel when valid & ready are both high at the clock edge.
  - Valid must not depend on ready.
  - i_r depends combinationally on i_v, o_v, o_r and ptr.
- take = ~o_v | o_r, i.e. the output register is empty or is being drained this cycle.
- Grant: when take=1, g = the first k with i_v[k]=1, searching k=ptr, ptr+1, …, ways-1, 0, …, ptr-1. i_r[g]=1; all other i_r bits are 0. If take=0 or no i_v is set, i_r=0.
- On an input accept:
  - o_v<=1, o_d<=i_d[g], o_s<=g.
  - ptr<=(g+1) mod ways. Wrap from ways-1 to 0 applies for non-power-of-two ways.
- take=1 with no i_v set: o_v<=0. o_d, o_s and ptr are held.
- o_v=1 and o_r=0 (stall): o_v, o_d, o_s are held stable and i_r=0.
- Simultaneous drain and refill (o_v=1, o_r=1, some i_v set): new beat loads in the same cycle. Throughput is one beat per clock.
- Latency: an input beat accepted at edge n appears on o_v/o_d at edge n (visible cycle n+1). There is no combinational path from i_d to o_d.
- Fairness: an input holding i_v=1 continuously is granted within at most ways accepted beats.
- Reset mid-transfer: a buffered beat is discarded (o_v→0 immediately) and ptr returns to 0.
- Data on non-granted inputs is ignored; their i_v may stay high indefinitely.

Optional Feature:
- Macro: BASE_RRMUX_LOCK_EN.
- Defined:
  - Adds the i_e port and a lock register (lock, lock_idx), both reset to 0.
  - When input g's beat is accepted with i_e[g]=0: lock<=1, lock_idx<=g.
  - While lock=1, only lock_idx is eligible for grant; other inputs are ignored even if valid.
  - Accepting a beat from lock_idx with i_e=1 clears lock. ptr advances to lock_idx+1 only on that final beat.
  - Single-beat packet (i_e=1 on the first beat) never sets lock.
- Undefined: no i_e port; every beat is arbitrated independently as described above.

Decomposition:
- Shared package base_pkg:
  - function clog2_min1 (returns ≥1) used to derive selw.
  - function rr_next(idx, ways) for pointer wrap.
- One sub-module base_rr_pick, purely combinational:
  - inputs: req[ways], ptr[selw]
  - outputs: gnt one-hot, gnt_idx, any
  - implemented as a double-width request vector with a priority search.
- base_rrmux holds all registers, the take logic and the optional lock.

Test Plan:
1. ways=3, width=8. Reset low then high. All i_v=1 with i_d={0x11,0x22,0x33}, o_r=1 → o_d sequence 0x11,0x22,0x33,0x11…; o_s=0,1,2,0; one beat per clock.
2. ways=3. i_v=3'b011, o_r=0 after the first accept → o_v=1 holds with o_d=0x11, o_s=0 stable; i_r=000 for the entire stall. Release o_r → next grant goes to input 1.
3. ways=5, ptr at 4, only i_v[1]=1 → grant wraps to 1; o_s=1; next ptr=2.
4. Single input toggling i_v with o_r=1 → o_v follows i_v delayed one cycle. With no requests, o_v drops to 0 while o_d/o_s hold their last value.
5. Assert reset mid-stream while o_v=1 → o_v=0, o_s=0 asynchronously, i_r=0. After release, first grant uses ptr=0.
6. With BASE_RRMUX_LOCK_EN, ways=2. Input 0 sends 3 beats with i_e=0,0,1 while i_v[1]=1 throughout → o_s=0,0,0 then 1. Without the macro → o_s alternates 0,1,0,1.

Source files
------------

// File: rtl/base_pkg.sv
// Shared helpers for the base_* valid/ready cells: index-width derivation and
// round-robin pointer wrap.
package base_pkg;

  // Never returns 0, so a 2-way (or 1-way) arbiter still gets a 1-bit index field.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Successor index with explicit wrap, valid for non-power-of-two way counts.
  function automatic int rr_next(input int idx, input int ways);
    return (idx >= ways - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/base_rr_pick.sv
// Combinational round-robin pick: the first set request at or after ptr, wrapping
// back through index 0. The request vector is doubled so one linear scan covers the wrap.
module base_rr_pick
  import base_pkg::*;
#(
  parameter int ways = 2,
  parameter int selw = clog2_min1(ways)
) (
  input  logic [ways-1:0] req,
  input  logic [selw-1:0] ptr,
  output logic [ways-1:0] gnt,
  output logic [selw-1:0] gnt_idx,
  output logic            any
);

  localparam int pw = selw + 1;

  logic [2*ways-1:0] dbl;
  logic [2*ways-1:0] rot;
  logic [pw-1:0]     pos;

  always_comb begin
    dbl     = {req, req};
    rot     = dbl >> ptr;
    gnt_idx = '0;
    any     = 1'b0;
    pos     = '0;
    for (int i = 0; i < ways; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        pos = {1'b0, ptr} + pw'(i);
        if (pos >= pw'(ways)) pos = pos - pw'(ways);
        gnt_idx = pos[selw-1:0];
      end
    end
    gnt = any ? (ways'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/base_rrmux.sv
// N-way round-robin valid/ready mux with a registered one-entry output stage.
// Define BASE_RRMUX_LOCK_EN to add i_e and hold the grant until end-of-packet.
module base_rrmux
  import base_pkg::*;
#(
  parameter int width = 1,
  parameter int ways  = 2,
  parameter int selw  = clog2_min1(ways)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ways-1:0]       i_v,
  input  logic [ways*width-1:0] i_d,
  output logic [ways-1:0]       i_r,
  output logic                  o_v,
  output logic [width-1:0]      o_d,
  output logic [selw-1:0]       o_s,
  input  logic                  o_r
`ifdef BASE_RRMUX_LOCK_EN
  ,
  input  logic [ways-1:0]       i_e
`endif
);

  logic [selw-1:0]  ptr;
  logic             take;
  logic             fire;
  logic [ways-1:0]  req;
  logic [ways-1:0]  gnt;
  logic [selw-1:0]  gnt_idx;
  logic             any;
  logic [width-1:0] sel_d;
  logic [selw-1:0]  ptr_next;

  assign take = ~o_v | o_r;

`ifdef BASE_RRMUX_LOCK_EN
  logic            lock;
  logic [selw-1:0] lock_idx;
  logic            last;

  // While a packet is open only its owner may compete.
  assign req  = lock ? (i_v & (ways'(1) << lock_idx)) : i_v;
  assign last = |(i_e & gnt);
`else
  assign req = i_v;
`endif

  base_rr_pick #(
    .ways(ways),
    .selw(selw)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .any    (any)
  );

  // Gating with reset keeps every ready low while reset is held.
  assign fire     = take & any & reset;
  assign i_r      = fire ? gnt : '0;
  assign ptr_next = selw'(rr_next(int'(gnt_idx), ways));

  always_comb begin
    sel_d = '0;
    for (int k = 0; k < ways; k++) begin
      if (gnt[k]) sel_d = sel_d | i_d[k*width +: width];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_v      <= 1'b0;
      o_d      <= '0;
      o_s      <= '0;
      ptr      <= '0;
`ifdef BASE_RRMUX_LOCK_EN
      lock     <= 1'b0;
      lock_idx <= '0;
`endif
    end else if (fire) begin
      o_v <= 1'b1;
      o_d <= sel_d;
      o_s <= gnt_idx;
`ifdef BASE_RRMUX_LOCK_EN
      // The pointer only moves past a source once its packet has closed.
      if (last) begin
        lock <= 1'b0;
        ptr  <= ptr_next;
      end else begin
        lock     <= 1'b1;
        lock_idx <= gnt_idx;
      end
`else
      ptr <= ptr_next;
`endif
    end else if (take) begin
      o_v <= 1'b0;
    end
  end

endmodule

// File: tb/tb_base_rrmux.sv
// Bench for base_rrmux: a 3-way instance checked against a behavioural model plus
// directed scenarios, and a 5-way instance for non-power-of-two pointer wrap.
module tb_base_rrmux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [2:0]  v3, r3, e3;
  logic [7:0]  dat3 [3];
  logic [23:0] d3;
  logic        ov3, or3;
  logic [7:0]  od3;
  logic [1:0]  os3;

  logic [4:0]  v5, r5, e5;
  logic [7:0]  dat5 [5];
  logic [39:0] d5;
  logic        ov5, or5;
  logic [7:0]  od5;
  logic [2:0]  os5;

  assign d3 = {dat3[2], dat3[1], dat3[0]};
  assign d5 = {dat5[4], dat5[3], dat5[2], dat5[1], dat5[0]};

  base_rrmux #(.width(8), .ways(3)) u3 (
    .clk(clk), .reset(reset), .i_v(v3), .i_d(d3), .i_r(r3),
    .o_v(ov3), .o_d(od3), .o_s(os3), .o_r(or3)
`ifdef BASE_RRMUX_LOCK_EN
    , .i_e(e3)
`endif
  );

  base_rrmux #(.width(8), .ways(5)) u5 (
    .clk(clk), .reset(reset), .i_v(v5), .i_d(d5), .i_r(r5),
    .o_v(ov5), .o_d(od5), .o_s(os5), .o_r(or5)
`ifdef BASE_RRMUX_LOCK_EN
    , .i_e(e5)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model for the 3-way instance, kept as plain integers.
  logic       m_ov;
  logic [7:0] m_od;
  int         m_os, m_ptr, m_g, m_lidx;
  logic       m_lock;
  logic [2:0] m_ir;

  task automatic model_reset();
    m_ov = 0; m_od = 0; m_os = 0; m_ptr = 0; m_g = -1; m_lock = 0; m_lidx = 0; m_ir = 0;
  endtask

  task automatic model_eval();
    m_g = -1;
    if (!m_ov || or3) begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (m_ptr + k) % 3;
        if (m_g < 0 && v3[idx] && (!m_lock || idx == m_lidx)) m_g = idx;
      end
    end
    m_ir = (m_g < 0) ? 3'b000 : 3'(1 << m_g);
  endtask

  task automatic model_commit();
    if (m_g >= 0) begin
      m_ov = 1;
      m_od = dat3[m_g];
      m_os = m_g;
`ifdef BASE_RRMUX_LOCK_EN
      if (e3[m_g]) begin
        m_lock = 0;
        m_ptr  = (m_g + 1) % 3;
      end else begin
        m_lock = 1;
        m_lidx = m_g;
      end
`else
      m_ptr = (m_g + 1) % 3;
`endif
    end else if (!m_ov || or3) begin
      m_ov = 0;
    end
  endtask

  task automatic do_reset();
    reset = 0;
    v3 = 0; v5 = 0; or3 = 0; or5 = 0; e3 = '1; e5 = '1;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1; v3 = '1; v5 = '1; or3 = 1; or5 = 1; e3 = '1; e5 = '1;
    for (int k = 0; k < 3; k++) dat3[k] = 8'hFF;
    for (int k = 0; k < 5; k++) dat5[k] = 8'hFF;
    #2 reset = 0;
    #1;
    total++; if (ov3 !== 1'b0) begin bad++; $display("FAIL reset_ov3 got=%0b want=0", ov3); end
    total++; if (od3 !== 8'h00) begin bad++; $display("FAIL reset_od3 got=%0h want=0", od3); end
    total++; if (os3 !== 2'd0) begin bad++; $display("FAIL reset_os3 got=%0d want=0", os3); end
    total++; if (r3 !== 3'b000) begin bad++; $display("FAIL reset_ir3 got=%b want=000", r3); end
    total++; if (ov5 !== 1'b0 || r5 !== 5'b0) begin bad++; $display("FAIL reset_u5 got ov=%0b ir=%b want 0/00000", ov5, r5); end
    @(posedge clk); #1;
    total++; if (ov3 !== 1'b0 || r3 !== 3'b000) begin bad++; $display("FAIL reset_hold got ov=%0b ir=%b want 0/000", ov3, r3); end
  endtask

  task automatic test_round_robin();
    do_reset();
    dat3[0] = 8'h11; dat3[1] = 8'h22; dat3[2] = 8'h33;
    v3 = 3'b111; or3 = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      model_eval();
      total++; if (r3 !== m_ir) begin bad++; $display("FAIL rr_ir cycle %0d got=%b want=%b", i, r3, m_ir); end
      @(posedge clk);
      model_commit();
      #1;
      total++; if (ov3 !== 1'b1 || os3 !== 2'(i % 3)) begin bad++; $display("FAIL rr_os cycle %0d got ov=%0b s=%0d want 1/%0d", i, ov3, os3, i % 3); end
      total++; if (od3 !== dat3[i % 3]) begin bad++; $display("FAIL rr_od cycle %0d got=%0h want=%0h", i, od3, dat3[i % 3]); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    dat3[0] = 8'h11; dat3[1] = 8'h22; dat3[2] = 8'h33;
    v3 = 3'b011; or3 = 1;
    @(negedge clk);
    total++; if (r3 !== 3'b001) begin bad++; $display("FAIL stall_first_ir got=%b want=001", r3); end
    @(posedge clk); #1;
    or3 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (r3 !== 3'b000) begin bad++; $display("FAIL stall_ir cycle %0d got=%b want=000", i, r3); end
      @(posedge clk); #1;
      total++; if (ov3 !== 1'b1 || od3 !== 8'h11 || os3 !== 2'd0) begin bad++; $display("FAIL stall_hold cycle %0d got ov=%0b d=%0h s=%0d want 1/11/0", i, ov3, od3, os3); end
    end
    or3 = 1;
    @(negedge clk);
    total++; if (r3 !== 3'b010) begin bad++; $display("FAIL stall_release_ir got=%b want=010", r3); end
    @(posedge clk); #1;
    total++; if (os3 !== 2'd1 || od3 !== 8'h22) begin bad++; $display("FAIL stall_release got s=%0d d=%0h want 1/22", os3, od3); end
    v3 = 0;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 5; k++) dat5[k] = 8'(8'h50 + k);
    or5 = 1; v5 = 5'b01000;
    @(posedge clk); #1;
    total++; if (os5 !== 3'd3) begin bad++; $display("FAIL wrap_setup got s=%0d want=3", os5); end
    v5 = 5'b00010;
    @(negedge clk);
    total++; if (r5 !== 5'b00010) begin bad++; $display("FAIL wrap_ir got=%b want=00010", r5); end
    @(posedge clk); #1;
    total++; if (os5 !== 3'd1 || od5 !== 8'h51) begin bad++; $display("FAIL wrap_grant got s=%0d d=%0h want 1/51", os5, od5); end
    v5 = 5'b00111;
    @(negedge clk);
    total++; if (r5 !== 5'b00100) begin bad++; $display("FAIL wrap_next_ptr got=%b want=00100", r5); end
    @(posedge clk); #1;
    total++; if (os5 !== 3'd2) begin bad++; $display("FAIL wrap_next_s got=%0d want=2", os5); end
    v5 = 0;
  endtask

  task automatic test_toggle();
    do_reset();
    or3 = 1;
    for (int i = 0; i < 30; i++) begin
      v3 = {2'b00, 1'($urandom_range(0, 1))};
      dat3[0] = 8'($urandom);
      @(negedge clk);
      model_eval();
      total++; if (r3 !== m_ir) begin bad++; $display("FAIL toggle_ir cycle %0d got=%b want=%b", i, r3, m_ir); end
      @(posedge clk);
      model_commit();
      #1;
      total++; if (ov3 !== v3[0]) begin bad++; $display("FAIL toggle_ov cycle %0d got=%0b want=%0b", i, ov3, v3[0]); end
      total++; if (od3 !== m_od || os3 !== 2'(m_os)) begin bad++; $display("FAIL toggle_hold cycle %0d got d=%0h s=%0d want %0h/%0d", i, od3, os3, m_od, m_os); end
    end
    v3 = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    dat3[0] = 8'h11; dat3[1] = 8'h22; dat3[2] = 8'h33;
    v3 = 3'b111; or3 = 1;
    repeat (2) @(posedge clk);
    #2 reset = 0;
    #1;
    total++; if (ov3 !== 1'b0 || os3 !== 2'd0 || od3 !== 8'h00) begin bad++; $display("FAIL midreset_out got ov=%0b s=%0d d=%0h want 0/0/0", ov3, os3, od3); end
    total++; if (r3 !== 3'b000) begin bad++; $display("FAIL midreset_ir got=%b want=000", r3); end
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    total++; if (r3 !== 3'b001) begin bad++; $display("FAIL midreset_ptr got=%b want=001", r3); end
    @(posedge clk); #1;
    total++; if (ov3 !== 1'b1 || os3 !== 2'd0 || od3 !== 8'h11) begin bad++; $display("FAIL midreset_first got ov=%0b s=%0d d=%0h want 1/0/11", ov3, os3, od3); end
    v3 = 0;
  endtask

  task automatic test_lock();
    int exp_s [4];
    int cnt0;
`ifdef BASE_RRMUX_LOCK_EN
    exp_s = '{0, 0, 0, 1};
`else
    exp_s = '{0, 1, 0, 1};
`endif
    do_reset();
    cnt0 = 0;
    dat3[1] = 8'hB1; dat3[2] = 8'h00;
    v3 = 3'b011; or3 = 1;
    for (int i = 0; i < 4; i++) begin
      e3 = {2'b11, 1'(cnt0 == 2)};
      dat3[0] = 8'(8'hA0 + cnt0);
      @(posedge clk); #1;
      total++; if (ov3 !== 1'b1 || os3 !== 2'(exp_s[i])) begin bad++; $display("FAIL lock_seq beat %0d got ov=%0b s=%0d want 1/%0d", i, ov3, os3, exp_s[i]); end
      if (exp_s[i] == 0) cnt0++;
    end
    v3 = 0; e3 = '1;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      v3  = 3'($urandom);
      or3 = ($urandom_range(0, 3) != 0);
      e3  = 3'($urandom);
      for (int k = 0; k < 3; k++) dat3[k] = 8'($urandom);
      @(negedge clk);
      model_eval();
      total++; if (r3 !== m_ir) begin bad++; $display("FAIL rand_ir cycle %0d got=%b want=%b", i, r3, m_ir); end
      @(posedge clk);
      model_commit();
      #1;
      total++; if (ov3 !== m_ov || od3 !== m_od || os3 !== 2'(m_os)) begin bad++; $display("FAIL rand_out cycle %0d got ov=%0b d=%0h s=%0d want %0b/%0h/%0d", i, ov3, od3, os3, m_ov, m_od, m_os); end
    end
    v3 = 0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_stall();
    test_wrap();
    test_toggle();
    test_reset_mid();
    test_lock();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
